// File: rtl/instr_split_queue_if.sv
// Handshake/bus bundle for instr_split_queue.
// Fetch side : in_valid, in_ready, in_word, in_pc.
// Decode side: out_valid, out_ready, out_pc and the pre-split fields of the head
//              word (opcode, rs, rt, rd, shamt, funct, immediate, imm_ext, jump_tgt).
// The slave modport belongs to the queue; master is the fetch/decode environment.
interface instr_split_queue_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned EXT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_word;
    logic [PC_W-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [15:0]      immediate;
    logic [EXT_W-1:0] imm_ext;
    logic [PC_W-1:0]  jump_tgt;

    modport slave (
        input  in_valid, in_word, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
               immediate, imm_ext, jump_tgt
    );

    modport master (
        output in_valid, in_word, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rs, rt, rd, shamt, funct,
               immediate, imm_ext, jump_tgt
    );
endinterface

// File: rtl/instr_split_queue.sv
// Decode-side instruction queue: DEPTH-entry first-word-fall-through FIFO of
// (word, pc) pairs with the head entry pre-split into MIPS fields.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   flush - synchronous queue clear for branch/jump redirect
//   bus   - instr_split_queue_if.slave (fetch push side, decode pop side, head fields)
module instr_split_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned EXT_W    = 32,
    parameter int unsigned LOGIC_ZX = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    instr_split_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Bits below 28 of the jump target come from the instruction, the rest from pc+4.
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(28'hFFF_FFFF);

    logic [31:0]     word_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready, out_valid, push, pop;

    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // Pointer/count next state; flush discards any push or pop of the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is intentionally not reset; out_valid gates everything read from it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            word_mem[wr_ptr_q] <= bus.in_word;
            pc_mem[wr_ptr_q]   <= bus.in_pc;
        end
    end

    logic [31:0]      head_word;
    logic [PC_W-1:0]  head_pc;
    logic [PC_W-1:0]  pc_plus4;
    logic [15:0]      imm;
    logic [5:0]       op;
    logic [EXT_W-1:0] imm_ext;

    assign head_word = out_valid ? word_mem[rd_ptr_q] : 32'h0;
    assign head_pc   = out_valid ? pc_mem[rd_ptr_q]   : '0;
    assign pc_plus4  = head_pc + PC_W'(4);
    assign imm       = head_word[15:0];
    assign op        = head_word[31:26];

    // Logical immediates zero-extend and LUI pre-shifts when LOGIC_ZX is set.
    always_comb begin
        imm_ext = EXT_W'(signed'(imm));
        if (LOGIC_ZX != 0) begin
            if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
                imm_ext = EXT_W'(imm);
            else if (op == 6'h0F)
                imm_ext = EXT_W'({imm, 16'h0000});
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = head_pc;
    assign bus.opcode    = head_word[31:26];
    assign bus.rs        = head_word[25:21];
    assign bus.rt        = head_word[20:16];
    assign bus.rd        = head_word[15:11];
    assign bus.shamt     = head_word[10:6];
    assign bus.funct     = head_word[5:0];
    assign bus.immediate = imm;
    assign bus.imm_ext   = imm_ext;
    assign bus.jump_tgt  = out_valid
                         ? ((pc_plus4 & ~LOW_MASK) | PC_W'({head_word[25:0], 2'b00}))
                         : '0;
endmodule

// File: tb/tb_instr_split_queue.sv
// Self-checking bench for instr_split_queue: directed scenarios plus a randomized
// run checked against a queue-based reference model. A second instance with
// LOGIC_ZX=0 shadows the same stimulus for the sign-extension variant.
module tb_instr_split_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned EXT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    instr_split_queue_if #(.PC_W(PC_W), .EXT_W(EXT_W)) bus ();
    instr_split_queue_if #(.PC_W(PC_W), .EXT_W(EXT_W)) bus_sx ();

    instr_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .EXT_W(EXT_W), .LOGIC_ZX(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave)
    );

    instr_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .EXT_W(EXT_W), .LOGIC_ZX(0)) dut_sx (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus_sx.slave)
    );

    assign bus_sx.in_valid  = bus.in_valid;
    assign bus_sx.in_word   = bus.in_word;
    assign bus_sx.in_pc     = bus.in_pc;
    assign bus_sx.out_ready = bus.out_ready;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference rules for the extended immediate.
    function automatic logic [31:0] m_ext(input logic [31:0] w, input bit zx);
        logic [5:0]  op;
        logic [15:0] imm;
        op  = w[31:26];
        imm = w[15:0];
        if (zx && (op == 6'h0C || op == 6'h0D || op == 6'h0E)) return {16'h0000, imm};
        if (zx && op == 6'h0F) return {imm, 16'h0000};
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] m_jt(input logic [31:0] w, input logic [31:0] pc);
        logic [31:0] s;
        s = pc + 32'd4;
        return {s[31:28], w[25:0], 2'b00};
    endfunction

    task automatic set_in(input logic v, input logic [31:0] w, input logic [31:0] pc,
                          input logic r);
        bus.in_valid  = v;
        bus.in_word   = w;
        bus.in_pc     = pc;
        bus.out_ready = r;
    endtask

    // Advance one clock and update the reference queue from the inputs at that edge.
    task automatic tick();
        bit do_push, do_pop;
        do_push = bus.in_valid && (q.size() < DEPTH);
        do_pop  = bus.out_ready && (q.size() != 0);
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({bus.in_word, bus.in_pc});
        end
        #1;
    endtask

    function automatic logic [31:0] head_word();
        return {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        n_checks++;
        if ({bus.out_pc, head_word(), bus.imm_ext, bus.jump_tgt} !== '0) begin
            n_fail++; $display("FAIL reset_fields got pc=%h w=%h ext=%h jt=%h want all 0",
                               bus.out_pc, head_word(), bus.imm_ext, bus.jump_tgt);
        end
    endtask

    task automatic test_rtype();
        set_in(1'b1, 32'h0022_1820, 32'h0040_0000, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rtype_no_bypass got out_valid=%b want 0", bus.out_valid);
        end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rtype_valid got %b want 1", bus.out_valid);
        end
        n_checks++;
        if ({bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct} !==
            {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}) begin
            n_fail++; $display("FAIL rtype_fields got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want 0/1/2/3/0/20",
                               bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct);
        end
        n_checks++;
        if (bus.out_pc !== 32'h0040_0000) begin
            n_fail++; $display("FAIL rtype_pc got %h want 00400000", bus.out_pc);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rtype_pop got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_extension();
        logic [31:0] w[3]      = '{32'h2008_FFFF, 32'h3508_FFFF, 32'h3C08_1234};
        logic [31:0] zx_exp[3] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h1234_0000};
        logic [31:0] sx_exp[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234};
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, w[i], 32'h100 + 32'(i * 4), 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.imm_ext !== zx_exp[i]) begin
                n_fail++; $display("FAIL ext_zx[%0d] got %h want %h", i, bus.imm_ext, zx_exp[i]);
            end
            n_checks++;
            if (bus_sx.imm_ext !== sx_exp[i]) begin
                n_fail++; $display("FAIL ext_sx[%0d] got %h want %h", i, bus_sx.imm_ext, sx_exp[i]);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_jump();
        logic [31:0] pcs[2] = '{32'hF000_0000, 32'hFFFF_FFFC};
        logic [31:0] exp[2] = '{32'hF000_0040, 32'h0000_0040};
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h0800_0010, pcs[i], 1'b0);
            tick();
            set_in(1'b0, 32'h0, 32'h0, 1'b0);
            n_checks++;
            if (bus.jump_tgt !== exp[i]) begin
                n_fail++; $display("FAIL jump[%0d] got %h want %h", i, bus.jump_tgt, exp[i]);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] pushed[$];
        for (int round = 0; round < 2; round++) begin
            pushed.delete();
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] w;
                w = $urandom;
                n_checks++;
                if (bus.in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL fill_ready[%0d] got %b want 1", i, bus.in_ready);
                end
                set_in(1'b1, w, 32'(i * 4), 1'b0);
                pushed.push_back(w);
                tick();
            end
            set_in(1'b1, 32'hBADC_0DE5, 32'h0, 1'b1);
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL full_in_ready got %b want 0", bus.in_ready);
            end
            tick();
            set_in(1'b0, 32'h0, 32'h0, 1'b1);
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL after_full_pop_ready got %b want 1", bus.in_ready);
            end
            for (int k = 1; k < DEPTH; k++) begin
                n_checks++;
                if (head_word() !== pushed[k] || bus.out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL drain_order[%0d] got %h v=%b want %h",
                                       k, head_word(), bus.out_valid, pushed[k]);
                end
                tick();
            end
            bus.out_ready = 1'b0;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL drain_empty got out_valid=%b word=%h want 0",
                                   bus.out_valid, head_word());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp[$];
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            w = $urandom;
            set_in(1'b1, w, 32'h0, 1'b0);
            exp.push_back(w);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            logic [31:0] w;
            w = $urandom;
            n_checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || head_word() !== exp[0]) begin
                n_fail++; $display("FAIL b2b[%0d] got rdy=%b v=%b w=%h want 1/1/%h",
                                   c, bus.in_ready, bus.out_valid, head_word(), exp[0]);
            end
            set_in(1'b1, w, 32'(c), 1'b1);
            void'(exp.pop_front());
            exp.push_back(w);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || head_word() !== exp[k]) begin
                n_fail++; $display("FAIL b2b_drain[%0d] got v=%b w=%h want 1/%h",
                                   k, bus.out_valid, head_word(), exp[k]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush(input bit use_rst);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'hA000_0000 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'hDEAD_BEEF, 32'h40, 1'b1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear%0d got v=%b rdy=%b want 0/1", use_rst, bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if ({bus.out_pc, head_word(), bus.imm_ext, bus.jump_tgt} !== '0) begin
            n_fail++; $display("FAIL clear%0d_fields got w=%h pc=%h want 0", use_rst, head_word(), bus.out_pc);
        end
        set_in(1'b1, 32'h1111_1111, 32'h80, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || head_word() !== 32'h1111_1111) begin
            n_fail++; $display("FAIL clear%0d_next got v=%b w=%h want 1/11111111", use_rst, bus.out_valid, head_word());
        end
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear%0d_stale got v=%b w=%h want 0", use_rst, bus.out_valid, head_word());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] w, pc;
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[31:26] = 6'($urandom_range(12, 15));
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            n_checks++;
            if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() != DEPTH)) begin
                n_fail++; $display("FAIL rnd_hs[%0d] got v=%b rdy=%b want size %0d",
                                   c, bus.out_valid, bus.in_ready, q.size());
            end
            if (q.size() != 0) begin
                n_checks++;
                if (head_word() !== q[0].w || bus.immediate !== q[0].w[15:0] ||
                    bus.out_pc !== q[0].pc) begin
                    n_fail++; $display("FAIL rnd_head[%0d] got w=%h pc=%h want w=%h pc=%h",
                                       c, head_word(), bus.out_pc, q[0].w, q[0].pc);
                end
                n_checks++;
                if (bus.imm_ext !== m_ext(q[0].w, 1'b1) || bus_sx.imm_ext !== m_ext(q[0].w, 1'b0)) begin
                    n_fail++; $display("FAIL rnd_ext[%0d] got zx=%h sx=%h want %h/%h", c,
                                       bus.imm_ext, bus_sx.imm_ext, m_ext(q[0].w, 1'b1), m_ext(q[0].w, 1'b0));
                end
                n_checks++;
                if (bus.jump_tgt !== m_jt(q[0].w, q[0].pc)) begin
                    n_fail++; $display("FAIL rnd_jt[%0d] got %h want %h", c, bus.jump_tgt, m_jt(q[0].w, q[0].pc));
                end
            end else begin
                n_checks++;
                if ({bus.out_pc, head_word(), bus.imm_ext, bus.jump_tgt} !== '0) begin
                    n_fail++; $display("FAIL rnd_idle[%0d] got w=%h pc=%h jt=%h want 0",
                                       c, head_word(), bus.out_pc, bus.jump_tgt);
                end
            end
            set_in(1'($urandom_range(0, 3) != 0), w, pc, 1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_rtype();
        test_extension();
        test_jump();
        test_fill_drain();
        test_back_to_back();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
